zeroriscy_prefetch_ctrl: RTL and testbench
==========================================

ZERORISCY_PREFETCH_CTRL -- requirements
Module: zeroriscy_prefetch_ctrl

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, the single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_i, in, 1, core requests instruction fetching.
- branch_i, in, 1, redirect fetch to addr_i this cycle.
- addr_i, in, 32, branch target; bit 1 may be set.
- busy_o, out, 1, a memory transaction is in flight.
- instr_req_o, out, 1, memory request.
- instr_addr_o, out, 32, memory word address; bits [1:0] always 0.
- instr_gnt_i, in, 1, memory grant.
- instr_rvalid_i, in, 1, response valid.
- instr_rdata_i, in, 32, response data.
- fifo_valid_o, out, 1, push to fetch FIFO.
- fifo_ready_i, in, 1, fetch FIFO has room.
- fifo_addr_o, out, 32, address of pushed word, bit 1 preserved.
- fifo_rdata_o, out, 32, pushed data.
- fifo_clear_o, out, 1, flush fetch FIFO.

REQ-002 SHALL be decided as follows: one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-003 SHALL keep req_addr_q (next word to request) and rsp_addr_q (address of the outstanding word), both 32 bit.
REQ-004 SHALL implement the FSM states IDLE, WAIT_GNT, WAIT_RVALID and WAIT_ABORTED, with at most one outstanding transaction.
REQ-005 SHALL drive instr_addr_o as {addr_i[31:2],2'b00} when branch_i=1, otherwise {req_addr_q[31:2],2'b00}.
REQ-006 SHALL drive fifo_clear_o = branch_i combinationally.
REQ-007 IDLE: SHALL assert instr_req_o = (req_i & fifo_ready_i) | branch_i; gnt -> WAIT_RVALID; request without gnt -> WAIT_GNT.
REQ-008 WAIT_GNT: SHALL hold instr_req_o=1 regardless of req_i and fifo_ready_i; gnt -> WAIT_RVALID; branch_i SHALL change the address in the same cycle.
REQ-009 On every grant, SHALL load rsp_addr_q with the requested address (addr_i including bit 1 on branch, else req_addr_q) and SHALL load req_addr_q <= {base[31:2]+1,2'b00}, wrapping 0xFFFFFFFC -> 0x00000000.
REQ-010 WAIT_RVALID: SHALL assert fifo_valid_o = instr_rvalid_i & ~branch_i, with fifo_addr_o = rsp_addr_q and fifo_rdata_o = instr_rdata_i.
REQ-011 WAIT_RVALID with branch_i and no rvalid SHALL go to WAIT_ABORTED and latch the target.
REQ-012 WAIT_RVALID with rvalid and branch_i SHALL discard the data and handle the branch as in IDLE in the following cycle.
REQ-013 WAIT_ABORTED: SHALL hold instr_req_o=0 and fifo_valid_o=0; rvalid SHALL be discarded and go to IDLE; a further branch_i SHALL update req_addr_q and stay in WAIT_ABORTED.
REQ-014 On branch_i without a grant in the same cycle, SHALL set req_addr_q <= addr_i, retaining bit 1 for the first fetch's fifo_addr_o.
REQ-015 SHALL set busy_o = (state != IDLE).
REQ-016 SHALL NOT push when fifo_ready_i=0 at request issue; a request SHALL only be issued with fifo_ready_i=1, except while in WAIT_GNT or on a branch.

Reset
REQ-017 On rst_n=0, SHALL asynchronously set state=IDLE and req_addr_q=rsp_addr_q=0.
REQ-018 While in reset, SHALL hold instr_req_o, fifo_valid_o, busy_o and fifo_clear_o at 0.
REQ-019 Reset mid-transaction SHALL drop the transaction without waiting for rvalid.

Configuration
REQ-020 Macro ZERORISCY_PF_PIPELINE_EN: when defined, in WAIT_RVALID or WAIT_ABORTED with instr_rvalid_i=1, SHALL evaluate the IDLE request rule in the same cycle (back-to-back issue); gnt -> WAIT_RVALID, else WAIT_GNT, else IDLE.
REQ-021 When ZERORISCY_PF_PIPELINE_EN is undefined, SHALL hold instr_req_o=0 in any cycle with rvalid and issue the next request at the earliest in IDLE on the following cycle.

Verification
REQ-022 Reset then branch_i=1 with addr_i=0x80 and gnt=1 -> instr_addr_o=0x80, next cycle WAIT_RVALID; rvalid with data 0xDEADBEEF -> fifo_valid_o=1, fifo_addr_o=0x80.
REQ-023 Branch to 0x102 -> instr_addr_o=0x100, fifo_addr_o=0x102; next request 0x104.
REQ-024 Branch in WAIT_RVALID to 0x200 -> state WAIT_ABORTED, no req; late rvalid -> fifo_valid_o=0; then request 0x200.
REQ-025 gnt withheld 3 cycles with req_i dropped -> instr_req_o stays 1 and the address stays stable.
REQ-026 req_addr_q=0xFFFFFFFC granted -> next instr_addr_o=0x00000000.
REQ-027 Continuous req_i, gnt=1, rvalid one cycle later -> one request per 2 cycles when ZERORISCY_PF_PIPELINE_EN is undefined, one per cycle when defined; fifo_ready_i=0 in IDLE -> no request.

Source files
------------

// File: rtl/zeroriscy_prefetch_ctrl.sv
// zeroriscy_prefetch_ctrl
//
// Instruction prefetch controller. Issues word fetches to instruction memory
// with at most one transaction outstanding and pushes the returned words into
// the fetch FIFO. A branch redirects fetching in the same cycle and flushes
// the FIFO. A response that is still in flight when a branch arrives is
// dropped on return.
//
// Build option: define ZERORISCY_PF_PIPELINE_EN to allow a new request in the
// same cycle a response returns (back-to-back fetch). When it is undefined,
// the next request goes out from IDLE at the earliest in the cycle after a
// response.

module zeroriscy_prefetch_ctrl (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    output logic        busy_o,

    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,

    output logic        fifo_valid_o,
    input  logic        fifo_ready_i,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_clear_o
);

`ifdef ZERORISCY_PF_PIPELINE_EN
    localparam logic PipelineEn = 1'b1;
`else
    localparam logic PipelineEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
        WAIT_ABORTED
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // next word to request (bit 1 kept after a branch until it is granted)
    logic [31:0] req_addr_q;
    // address of the word currently outstanding, as seen by the FIFO
    logic [31:0] rsp_addr_q;

    logic [31:0] fetch_addr;
    logic        idle_req;
    logic        rsp_issue;
    logic        granted;

    // Address presented this cycle: a branch target overrides the sequential one.
    assign fetch_addr   = branch_i ? addr_i : req_addr_q;
    assign instr_addr_o = {fetch_addr[31:2], 2'b00};

    // Request condition used in IDLE (and, pipelined, in a response cycle).
    assign idle_req  = (req_i & fifo_ready_i) | branch_i;
    assign rsp_issue = PipelineEn & instr_rvalid_i & idle_req;
    assign granted   = instr_req_o & instr_gnt_i;

    assign busy_o       = (state_q != IDLE);
    assign fifo_clear_o = branch_i & rst_n;
    assign fifo_addr_o  = rsp_addr_q;
    assign fifo_rdata_o = instr_rdata_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A response cycle that also issues a request (only
    // possible when pipelined) follows the same gnt/no-gnt split as IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (instr_req_o) begin
                    state_d = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (instr_gnt_i) begin
                    state_d = WAIT_RVALID;
                end
            end
            WAIT_RVALID, WAIT_ABORTED: begin
                if (instr_rvalid_i) begin
                    if (instr_req_o) begin
                        state_d = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (branch_i) begin
                    state_d = WAIT_ABORTED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: memory request and FIFO push per state, all forced low in reset.
    always_comb begin
        instr_req_o  = 1'b0;
        fifo_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                instr_req_o = idle_req;
            end
            WAIT_GNT: begin
                instr_req_o = 1'b1;
            end
            WAIT_RVALID: begin
                fifo_valid_o = instr_rvalid_i & ~branch_i;
                instr_req_o  = rsp_issue;
            end
            WAIT_ABORTED: begin
                instr_req_o = rsp_issue;
            end
            default: begin
                instr_req_o  = 1'b0;
                fifo_valid_o = 1'b0;
            end
        endcase
        if (!rst_n) begin
            instr_req_o  = 1'b0;
            fifo_valid_o = 1'b0;
        end
    end

    // Address registers: a grant advances to the next word; an ungranted
    // branch only remembers its target (bit 1 included) for the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_q <= '0;
            rsp_addr_q <= '0;
        end else if (granted) begin
            rsp_addr_q <= fetch_addr;
            req_addr_q <= {fetch_addr[31:2] + 30'd1, 2'b00};
        end else if (branch_i) begin
            req_addr_q <= addr_i;
        end
    end

    // Handshake sanity properties.
    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        instr_addr_o[1:0] == 2'b00);

    a_gnt_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == WAIT_GNT && !instr_gnt_i) |=> instr_req_o);

    a_push_only_in_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_valid_o |-> (state_q == WAIT_RVALID));

    a_no_req_while_waiting: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == WAIT_RVALID || state_q == WAIT_ABORTED) && !instr_rvalid_i) |-> !instr_req_o);

endmodule

// File: tb/tb_zeroriscy_prefetch_ctrl.sv
// Testbench for zeroriscy_prefetch_ctrl: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.

module tb_zeroriscy_prefetch_ctrl;

`ifdef ZERORISCY_PF_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic        branch_i;
    logic [31:0] addr_i;
    logic        busy_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        fifo_valid_o;
    logic        fifo_ready_i;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_clear_o;

    int checks = 0;
    int passed = 0;

    // Reference model: transaction bookkeeping rather than controller states.
    logic [31:0] m_next;      // next address to fetch (bit 1 may be set)
    logic        m_wgnt;      // a request is waiting for its grant
    logic        m_out;       // a granted word has not returned yet
    logic        m_drop;      // the outstanding word will be discarded
    logic [31:0] m_out_addr;  // address of the outstanding word
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic        e_fv;

    zeroriscy_prefetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .busy_o         (busy_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_ready_i   (fifo_ready_i),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_clear_o   (fifo_clear_o)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_next     = '0;
        m_wgnt     = 1'b0;
        m_out      = 1'b0;
        m_drop     = 1'b0;
        m_out_addr = '0;
    endfunction

    function automatic void model_predict();
        logic resp_now;
        logic may_issue;
        resp_now  = m_out && instr_rvalid_i;
        may_issue = (!m_wgnt && !m_out) || (PIPE && resp_now);
        e_req  = m_wgnt || (may_issue && ((req_i && fifo_ready_i) || branch_i));
        e_addr = (branch_i ? addr_i : m_next) & 32'hFFFF_FFFC;
        e_busy = m_wgnt || m_out;
        e_fv   = resp_now && !m_drop && !branch_i;
    endfunction

    function automatic void model_update();
        logic [31:0] base;
        logic        resp_now;
        model_predict();
        resp_now = m_out && instr_rvalid_i;
        base     = branch_i ? addr_i : m_next;
        if (resp_now) m_out = 1'b0;
        else if (m_out && branch_i) m_drop = 1'b1;
        if (e_req && instr_gnt_i) begin
            m_wgnt     = 1'b0;
            m_out      = 1'b1;
            m_drop     = 1'b0;
            m_out_addr = base;
            m_next     = (base & 32'hFFFF_FFFC) + 32'd4;
        end else begin
            if (branch_i) m_next = addr_i;
            if (e_req) m_wgnt = 1'b1;
        end
    endfunction

    task automatic set_in(input logic r, input logic b, input logic [31:0] a,
                          input logic g, input logic v, input logic [31:0] d,
                          input logic rd);
        req_i          = r;
        branch_i       = b;
        addr_i         = a;
        instr_gnt_i    = g;
        instr_rvalid_i = v;
        instr_rdata_i  = d;
        fifo_ready_i   = rd;
    endtask

    task automatic finish_cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", instr_req_o); else passed++;
        checks++; if (fifo_clear_o !== 1'b0) $display("FAIL reset_clear: got %b want 0", fifo_clear_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else passed++;
        checks++; if (fifo_valid_o !== 1'b0) $display("FAIL reset_fv: got %b want 0", fifo_valid_o); else passed++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (instr_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", instr_addr_o); else passed++;
        checks++; if (instr_req_o !== 1'b0) $display("FAIL reset_idle_req: got %b want 0", instr_req_o); else passed++;
        finish_cycle();
    endtask

    task automatic test_branch_basic();
        set_in(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1) $display("FAIL br_req: got %b want 1", instr_req_o); else passed++;
        checks++; if (instr_addr_o !== 32'h80) $display("FAIL br_addr: got %h want 00000080", instr_addr_o); else passed++;
        checks++; if (fifo_clear_o !== 1'b1) $display("FAIL br_clear: got %b want 1", fifo_clear_o); else passed++;
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (busy_o !== 1'b1) $display("FAIL br_busy: got %b want 1", busy_o); else passed++;
        checks++; if (instr_req_o !== 1'b0) $display("FAIL br_wait_req: got %b want 0", instr_req_o); else passed++;
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1) $display("FAIL br_fv: got %b want 1", fifo_valid_o); else passed++;
        checks++; if (fifo_addr_o !== 32'h80) $display("FAIL br_faddr: got %h want 00000080", fifo_addr_o); else passed++;
        checks++; if (fifo_rdata_o !== 32'hDEAD_BEEF) $display("FAIL br_rdata: got %h want deadbeef", fifo_rdata_o); else passed++;
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) $display("FAIL br_idle_busy: got %b want 0", busy_o); else passed++;
        finish_cycle();
    endtask

    task automatic test_branch_align();
        set_in(1'b0, 1'b1, 32'h102, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (instr_addr_o !== 32'h100) $display("FAIL al_addr: got %h want 00000100", instr_addr_o); else passed++;
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
        @(negedge clk);
        checks++; if (fifo_addr_o !== 32'h102) $display("FAIL al_faddr: got %h want 00000102", fifo_addr_o); else passed++;
        finish_cycle();
        set_in(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1) $display("FAIL al_next_req: got %b want 1", instr_req_o); else passed++;
        checks++; if (instr_addr_o !== 32'h104) $display("FAIL al_next_addr: got %h want 00000104", instr_addr_o); else passed++;
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b1);
        @(negedge clk);
        checks++; if (fifo_addr_o !== 32'h104) $display("FAIL al_next_faddr: got %h want 00000104", fifo_addr_o); else passed++;
        finish_cycle();
    endtask

    task automatic test_gnt_stall();
        set_in(1'b0, 1'b1, 32'h3A0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1) $display("FAIL st_req0: got %b want 1", instr_req_o); else passed++;
        finish_cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
            @(negedge clk);
            checks++; if (instr_req_o !== 1'b1) $display("FAIL st_req%0d: got %b want 1", i + 1, instr_req_o); else passed++;
            checks++; if (instr_addr_o !== 32'h3A0) $display("FAIL st_addr%0d: got %h want 000003a0", i + 1, instr_addr_o); else passed++;
            finish_cycle();
        end
        set_in(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (instr_addr_o !== 32'h3A0) $display("FAIL st_gnt_addr: got %h want 000003a0", instr_addr_o); else passed++;
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1) $display("FAIL st_fv: got %b want 1", fifo_valid_o); else passed++;
        checks++; if (fifo_addr_o !== 32'h3A0) $display("FAIL st_faddr: got %h want 000003a0", fifo_addr_o); else passed++;
        finish_cycle();
    endtask

    task automatic test_abort();
        set_in(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        finish_cycle();
        set_in(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b0) $display("FAIL ab_req: got %b want 0", instr_req_o); else passed++;
        checks++; if (fifo_clear_o !== 1'b1) $display("FAIL ab_clear: got %b want 1", fifo_clear_o); else passed++;
        finish_cycle();
        set_in(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (busy_o !== 1'b1) $display("FAIL ab_busy: got %b want 1", busy_o); else passed++;
        checks++; if (instr_req_o !== 1'b0) $display("FAIL ab_hold_req: got %b want 0", instr_req_o); else passed++;
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h5555_AAAA, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b0) $display("FAIL ab_late_fv: got %b want 0", fifo_valid_o); else passed++;
        finish_cycle();
        set_in(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1) $display("FAIL ab_new_req: got %b want 1", instr_req_o); else passed++;
        checks++; if (instr_addr_o !== 32'h200) $display("FAIL ab_new_addr: got %h want 00000200", instr_addr_o); else passed++;
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h7777_0000, 1'b1);
        @(negedge clk);
        checks++; if (fifo_addr_o !== 32'h200) $display("FAIL ab_faddr: got %h want 00000200", fifo_addr_o); else passed++;
        finish_cycle();
    endtask

    task automatic test_wrap();
        set_in(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h1111_2222, 1'b1);
        @(negedge clk);
        checks++; if (fifo_addr_o !== 32'hFFFF_FFFC) $display("FAIL wr_faddr: got %h want fffffffc", fifo_addr_o); else passed++;
        finish_cycle();
        set_in(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (instr_addr_o !== 32'h0) $display("FAIL wr_addr: got %h want 00000000", instr_addr_o); else passed++;
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h3333_4444, 1'b1);
        @(negedge clk);
        checks++; if (fifo_addr_o !== 32'h0) $display("FAIL wr_faddr0: got %h want 00000000", fifo_addr_o); else passed++;
        finish_cycle();
    endtask

    task automatic test_reset_mid();
        set_in(1'b0, 1'b1, 32'h500, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy_o); else passed++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1) $display("FAIL rm_req: got %b want 1", instr_req_o); else passed++;
        checks++; if (instr_addr_o !== 32'h0) $display("FAIL rm_addr: got %h want 00000000", instr_addr_o); else passed++;
        finish_cycle();
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h9999_8888, 1'b1);
        @(negedge clk);
        checks++; if (fifo_addr_o !== 32'h0) $display("FAIL rm_faddr: got %h want 00000000", fifo_addr_o); else passed++;
        finish_cycle();
    endtask

    task automatic test_back_to_back();
        int grants;
        int want;
        grants = 0;
        want   = PIPE ? 20 : 10;
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b1, m_out, $urandom, 1'b1);
            @(negedge clk);
            if (instr_req_o === 1'b1) grants++;
            finish_cycle();
        end
        checks++; if (grants !== want) $display("FAIL b2b_grants: got %0d want %0d", grants, want); else passed++;
        set_in(1'b0, 1'b0, '0, 1'b0, m_out, $urandom, 1'b1);
        @(negedge clk);
        finish_cycle();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
            @(negedge clk);
            checks++; if (instr_req_o !== 1'b0) $display("FAIL notready_req%0d: got %b want 0", i, instr_req_o); else passed++;
            checks++; if (busy_o !== 1'b0) $display("FAIL notready_busy%0d: got %b want 0", i, busy_o); else passed++;
            finish_cycle();
        end
    endtask

    task automatic test_random();
        logic        br;
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
            br = ($urandom_range(0, 5) == 0);
            a  = $urandom & 32'hFFFF_FFFE;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | (a & 32'h2);
            set_in($urandom_range(0, 3) != 0, br, a, $urandom_range(0, 1) != 0,
                   m_out && ($urandom_range(0, 2) != 0), $urandom, $urandom_range(0, 4) != 0);
            @(negedge clk);
            model_predict();
            checks++; if (instr_req_o !== e_req) $display("FAIL rnd_req@%0d: got %b want %b", i, instr_req_o, e_req); else passed++;
            checks++; if (instr_addr_o !== e_addr) $display("FAIL rnd_addr@%0d: got %h want %h", i, instr_addr_o, e_addr); else passed++;
            checks++; if (busy_o !== e_busy) $display("FAIL rnd_busy@%0d: got %b want %b", i, busy_o, e_busy); else passed++;
            checks++; if (fifo_clear_o !== br) $display("FAIL rnd_clear@%0d: got %b want %b", i, fifo_clear_o, br); else passed++;
            checks++; if (fifo_valid_o !== e_fv) $display("FAIL rnd_fv@%0d: got %b want %b", i, fifo_valid_o, e_fv); else passed++;
            if (e_fv) begin
                checks++; if (fifo_addr_o !== m_out_addr) $display("FAIL rnd_faddr@%0d: got %h want %h", i, fifo_addr_o, m_out_addr); else passed++;
                checks++; if (fifo_rdata_o !== instr_rdata_i) $display("FAIL rnd_rdata@%0d: got %h want %h", i, fifo_rdata_o, instr_rdata_i); else passed++;
            end
            finish_cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        model_reset();
        test_reset();
        test_branch_basic();
        test_branch_align();
        test_gnt_stall();
        test_abort();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
